// File: rtl/vote_tally.sv
// Per-candidate EVM vote tally with lockout, multi-press reject and gated readout; optional VOTE_TALLY_CLEAR_EN adds clear_tally.
// Latency: counters update on the accepting edge; ack/reject/busy registered; readout valid one cycle after entering RESULT.
// Backpressure: none; pulses during LOCKOUT or RESULT are dropped, simultaneous presses are rejected.
module vote_tally #(
    parameter int NUM_CAND       = 4,
    parameter int CNT_W          = 16,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mode,
    input  logic [NUM_CAND-1:0]         valid_vote,
    input  logic [$clog2(NUM_CAND)-1:0] sel,
`ifdef VOTE_TALLY_CLEAR_EN
    input  logic                        clear_tally,
`endif
    output logic [CNT_W-1:0]            vote_count,
    output logic [CNT_W-1:0]            total_votes,
    output logic                        vote_ack,
    output logic                        vote_reject,
    output logic                        busy
);

    localparam int SEL_W = $clog2(NUM_CAND);
    localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOCKOUT = 2'd1,
        S_RESULT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LCK_W-1:0]  lock_q, lock_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CAND];
    logic [CNT_W-1:0]  cnt_d [NUM_CAND];
    logic [CNT_W-1:0]  total_q, total_d;
    logic              ack_d, rej_d;

    logic              multi_press;
    logic              one_press;
    logic [NUM_CAND-1:0] sat_vec;
    logic [CNT_W-1:0]  rd_count;
    logic              show;

    assign multi_press = (valid_vote & (valid_vote - 1'b1)) != '0;
    assign one_press   = (valid_vote != '0) && !multi_press;

    always_comb begin
        sat_vec  = '0;
        rd_count = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            sat_vec[i] = &cnt_q[i];
            if (sel == SEL_W'(i)) rd_count = cnt_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        ack_d   = 1'b0;
        rej_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mode) begin
                    state_d = S_RESULT;
                end else if (one_press) begin
                    ack_d   = 1'b1;
                    state_d = S_LOCKOUT;
                    lock_d  = LCK_W'(LOCKOUT_CYCLES);
                    // A vote for a saturated candidate is acked but leaves every counter alone.
                    if ((valid_vote & sat_vec) == '0) begin
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (valid_vote[i]) cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                        if (!(&total_q)) total_d = total_q + 1'b1;
                    end
                end else if (multi_press) begin
                    rej_d = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (mode) begin
                    state_d = S_RESULT;
                    lock_d  = '0;
                end else if (lock_q <= LCK_W'(1)) begin
                    state_d = S_IDLE;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q - 1'b1;
                end
            end
            S_RESULT: begin
                if (!mode) state_d = S_IDLE;
`ifdef VOTE_TALLY_CLEAR_EN
                if (clear_tally) begin
                    for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
                    total_d = '0;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                lock_d  = '0;
            end
        endcase
    end

    // Readout only while RESULT was held across the edge, so leaving RESULT blanks at once.
    assign show = (state_q == S_RESULT) && (state_d == S_RESULT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lock_q      <= '0;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total_q     <= '0;
            vote_count  <= '0;
            total_votes <= '0;
            vote_ack    <= 1'b0;
            vote_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            vote_count  <= show ? rd_count : '0;
            total_votes <= show ? total_q : '0;
            vote_ack    <= ack_d;
            vote_reject <= rej_d;
            busy        <= (state_d == S_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: directed scenarios plus a randomized run against an event-level tally model.
module tb_vote_tally;

    localparam int NC   = 5;
    localparam int CW   = 4;
    localparam int LC   = 8;
    localparam int SW   = $clog2(NC);
    localparam int MAXV = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          mode;
    logic          clear_tally;
    logic [NC-1:0] valid_vote;
    logic [SW-1:0] sel;
    logic [CW-1:0] vote_count;
    logic [CW-1:0] total_votes;
    logic          vote_ack;
    logic          vote_reject;
    logic          busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    vote_tally #(.NUM_CAND(NC), .CNT_W(CW), .LOCKOUT_CYCLES(LC)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .valid_vote  (valid_vote),
        .sel         (sel),
`ifdef VOTE_TALLY_CLEAR_EN
        .clear_tally (clear_tally),
`endif
        .vote_count  (vote_count),
        .total_votes (total_votes),
        .vote_ack    (vote_ack),
        .vote_reject (vote_reject),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Event-level model: tallies, remaining lockout cycles, and whether readout mode is held.
    int m_cnt [NC];
    int m_total, m_lock;
    bit m_res;
    int exp_vc, exp_tot, exp_ack, exp_rej, exp_busy;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
        m_total = 0; m_lock = 0; m_res = 0;
        exp_vc = 0; exp_tot = 0; exp_ack = 0; exp_rej = 0; exp_busy = 0;
    endtask

    task automatic model_step(input bit md, input logic [NC-1:0] vv, input int s);
        bit was_res;
        int n;
        was_res = m_res;
        n = $countones(vv);
        exp_ack = 0;
        exp_rej = 0;
        if (m_res) begin
            if (!md) m_res = 0;
        end else if (md) begin
            m_res  = 1;
            m_lock = 0;
        end else if (m_lock > 0) begin
            m_lock = m_lock - 1;
        end else if (n == 1) begin
            exp_ack = 1;
            for (int i = 0; i < NC; i++) begin
                if (vv[i] && m_cnt[i] < MAXV) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_total < MAXV) m_total = m_total + 1;
                end
            end
            m_lock = LC;
        end else if (n > 1) begin
            exp_rej = 1;
        end
        exp_busy = (m_lock > 0) ? 1 : 0;
        if (was_res && m_res) begin
            exp_tot = m_total;
            exp_vc  = (s < NC) ? m_cnt[s] : 0;
        end else begin
            exp_tot = 0;
            exp_vc  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mode = 1'b0; valid_vote = '0; sel = '0; clear_tally = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; valid_vote = '0; sel = '0; clear_tally = 1'b0;
        tick();
        total_cnt++; if (vote_count !== '0) begin bad_cnt++; $display("FAIL reset_vc: got %0d want 0", vote_count); end
        total_cnt++; if (total_votes !== '0) begin bad_cnt++; $display("FAIL reset_tot: got %0d want 0", total_votes); end
        total_cnt++; if ({vote_ack, vote_reject, busy} !== 3'b000) begin bad_cnt++; $display("FAIL reset_flags: got %b want 000", {vote_ack, vote_reject, busy}); end
        reset = 1'b0;
    endtask

    task automatic test_single_vote();
        int acks, busys;
        do_reset();
        acks = 0; busys = 0;
        valid_vote = 5'b00100;
        for (int k = 0; k < 10; k++) begin
            tick();
            valid_vote = '0;
            acks  += int'(vote_ack);
            busys += int'(busy);
        end
        total_cnt++; if (acks != 1) begin bad_cnt++; $display("FAIL single_ack_cycles: got %0d want 1", acks); end
        total_cnt++; if (busys != LC) begin bad_cnt++; $display("FAIL single_busy_cycles: got %0d want %0d", busys, LC); end
        mode = 1'b1; sel = 3'd2;
        tick();
        total_cnt++; if (vote_count !== 4'd0) begin bad_cnt++; $display("FAIL single_entry_blank: got %0d want 0", vote_count); end
        tick();
        total_cnt++; if (vote_count !== 4'd1) begin bad_cnt++; $display("FAIL single_vc: got %0d want 1", vote_count); end
        total_cnt++; if (total_votes !== 4'd1) begin bad_cnt++; $display("FAIL single_tot: got %0d want 1", total_votes); end
        mode = 1'b0;
    endtask

    task automatic test_lockout_ignore();
        do_reset();
        valid_vote = 5'b00010;
        tick();
        valid_vote = '0;
        tick(); tick();
        valid_vote = 5'b00010;
        tick();
        total_cnt++; if (vote_ack !== 1'b0) begin bad_cnt++; $display("FAIL lock_ack: got %b want 0", vote_ack); end
        valid_vote = '0;
        repeat (10) tick();
        mode = 1'b1; sel = 3'd1;
        tick(); tick();
        total_cnt++; if (vote_count !== 4'd1) begin bad_cnt++; $display("FAIL lock_vc: got %0d want 1", vote_count); end
        total_cnt++; if (total_votes !== 4'd1) begin bad_cnt++; $display("FAIL lock_tot: got %0d want 1", total_votes); end
        mode = 1'b0;
    endtask

    task automatic test_reject();
        do_reset();
        valid_vote = 5'b00101;
        tick();
        total_cnt++; if ({vote_reject, vote_ack} !== 2'b10) begin bad_cnt++; $display("FAIL rej_pulse: got %b want 10", {vote_reject, vote_ack}); end
        valid_vote = 5'b01000;
        tick();
        total_cnt++; if ({vote_reject, vote_ack} !== 2'b01) begin bad_cnt++; $display("FAIL rej_next_accept: got %b want 01", {vote_reject, vote_ack}); end
        valid_vote = '0;
        repeat (9) tick();
        mode = 1'b1; sel = 3'd0;
        tick(); tick();
        total_cnt++; if (vote_count !== 4'd0) begin bad_cnt++; $display("FAIL rej_c0: got %0d want 0", vote_count); end
        sel = 3'd3;
        tick();
        total_cnt++; if (vote_count !== 4'd1) begin bad_cnt++; $display("FAIL rej_c3: got %0d want 1", vote_count); end
        total_cnt++; if (total_votes !== 4'd1) begin bad_cnt++; $display("FAIL rej_tot: got %0d want 1", total_votes); end
        mode = 1'b0;
    endtask

    task automatic test_mode_abort();
        do_reset();
        valid_vote = 5'b00001;
        tick();
        valid_vote = '0;
        tick(); tick();
        total_cnt++; if (busy !== 1'b1) begin bad_cnt++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        mode = 1'b1;
        tick();
        total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL abort_busy_result: got %b want 0", busy); end
        mode = 1'b0;
        tick();
        total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL abort_busy_idle: got %b want 0", busy); end
        valid_vote = 5'b00001;
        tick();
        total_cnt++; if ({vote_ack, busy} !== 2'b11) begin bad_cnt++; $display("FAIL abort_first_idle_vote: got %b want 11", {vote_ack, busy}); end
        valid_vote = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < MAXV; k++) begin
            valid_vote = 5'b01000;
            tick();
            valid_vote = '0;
            repeat (LC) tick();
        end
        valid_vote = 5'b01000;
        tick();
        total_cnt++; if (vote_ack !== 1'b1) begin bad_cnt++; $display("FAIL sat_ack: got %b want 1", vote_ack); end
        valid_vote = '0;
        repeat (LC) tick();
        valid_vote = 5'b00001;
        tick();
        total_cnt++; if (vote_ack !== 1'b1) begin bad_cnt++; $display("FAIL sat_other_ack: got %b want 1", vote_ack); end
        valid_vote = '0;
        repeat (LC) tick();
        mode = 1'b1; sel = 3'd3;
        tick(); tick();
        total_cnt++; if (vote_count !== 4'd15) begin bad_cnt++; $display("FAIL sat_vc: got %0d want 15", vote_count); end
        total_cnt++; if (total_votes !== 4'd15) begin bad_cnt++; $display("FAIL sat_tot: got %0d want 15", total_votes); end
        sel = 3'd0;
        tick();
        total_cnt++; if (vote_count !== 4'd1) begin bad_cnt++; $display("FAIL sat_c0: got %0d want 1", vote_count); end
        sel = 3'd6;
        tick();
        total_cnt++; if (vote_count !== 4'd0) begin bad_cnt++; $display("FAIL sel_oob: got %0d want 0", vote_count); end
        mode = 1'b0;
        tick();
        total_cnt++; if ({vote_count, total_votes} !== 8'd0) begin bad_cnt++; $display("FAIL exit_secrecy: got %h want 00", {vote_count, total_votes}); end
    endtask

    task automatic test_reset_mid_lockout();
        do_reset();
        valid_vote = 5'b10000;
        tick();
        valid_vote = '0;
        tick();
        #2 reset = 1'b1;
        #1;
        total_cnt++; if ({busy, vote_ack, vote_reject} !== 3'b000) begin bad_cnt++; $display("FAIL midreset_flags: got %b want 000", {busy, vote_ack, vote_reject}); end
        tick();
        reset = 1'b0;
        mode = 1'b1; sel = 3'd4;
        tick(); tick();
        total_cnt++; if ({vote_count, total_votes} !== 8'd0) begin bad_cnt++; $display("FAIL midreset_counts: got %h want 00", {vote_count, total_votes}); end
        mode = 1'b0;
        tick();
    endtask

`ifdef VOTE_TALLY_CLEAR_EN
    task automatic test_clear();
        logic [NC-1:0] seq [3];
        seq[0] = 5'b00001; seq[1] = 5'b00010; seq[2] = 5'b00010;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            valid_vote = seq[k];
            tick();
            valid_vote = '0;
            repeat (LC) tick();
        end
        mode = 1'b1; sel = 3'd1;
        tick(); tick();
        total_cnt++; if ({vote_count, total_votes} !== {4'd2, 4'd3}) begin bad_cnt++; $display("FAIL clr_pre: got %h want 23", {vote_count, total_votes}); end
        clear_tally = 1'b1;
        tick();
        clear_tally = 1'b0;
        tick();
        total_cnt++; if ({vote_count, total_votes} !== 8'd0) begin bad_cnt++; $display("FAIL clr_post: got %h want 00", {vote_count, total_votes}); end
        sel = 3'd0;
        tick();
        total_cnt++; if (vote_count !== 4'd0) begin bad_cnt++; $display("FAIL clr_c0: got %0d want 0", vote_count); end
        mode = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        bit md;
        int r, s;
        logic [NC-1:0] vv;
        md = 0;
        for (int c = 0; c < 900; c++) begin
            if (c % 300 == 0) begin
                do_reset();
                md = 0;
            end
            if ($urandom_range(0, 24) == 0) md = ~md;
            r = $urandom_range(0, 9);
            if (r < 6)      vv = '0;
            else if (r < 9) vv = NC'(1) << $urandom_range(0, NC - 1);
            else            vv = NC'($urandom);
            s = $urandom_range(0, (1 << SW) - 1);
            mode = md; valid_vote = vv; sel = SW'(s);
            tick();
            model_step(md, vv, s);
            total_cnt++; if (vote_ack !== exp_ack[0]) begin bad_cnt++; $display("FAIL rnd_ack c=%0d: got %b want %0d", c, vote_ack, exp_ack); end
            total_cnt++; if (vote_reject !== exp_rej[0]) begin bad_cnt++; $display("FAIL rnd_rej c=%0d: got %b want %0d", c, vote_reject, exp_rej); end
            total_cnt++; if (busy !== exp_busy[0]) begin bad_cnt++; $display("FAIL rnd_busy c=%0d: got %b want %0d", c, busy, exp_busy); end
            total_cnt++; if (vote_count !== CW'(exp_vc)) begin bad_cnt++; $display("FAIL rnd_vc c=%0d: got %0d want %0d", c, vote_count, exp_vc); end
            total_cnt++; if (total_votes !== CW'(exp_tot)) begin bad_cnt++; $display("FAIL rnd_tot c=%0d: got %0d want %0d", c, total_votes, exp_tot); end
        end
        mode = 1'b0; valid_vote = '0;
    endtask

    initial begin
        test_reset();
        test_single_vote();
        test_lockout_ignore();
        test_reject();
        test_mode_abort();
        test_saturation();
        test_reset_mid_lockout();
`ifdef VOTE_TALLY_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
